// File: rtl/sram_mem_ctrl.sv
// Multi-cycle MEM-stage data memory controller for a 256Kx16 asynchronous SRAM.
// Each 32-bit access is split into a low and a high half-word phase; ready stalls the pipeline meanwhile.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_value,
  output logic [31:0] dataMem_out,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [16:0] wa;
  logic [15:0] wdata_hi;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        is_wr;
  logic        req;
  logic        unused_addr_bits;

  // Handshake: ready=1 means the pipeline may advance at the next edge. A request
  // held in IDLE drops ready in the same cycle; DONE raises it for exactly one cycle.
  assign req     = MEM_R_EN | MEM_W_EN;
  assign ready   = (state == DONE) | ((state == IDLE) & ~req);
  assign cnt_nxt = cnt + 4'd1;

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign unused_addr_bits = ^{ALU_result[31:19], ALU_result[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wa          <= 17'd0;
      wdata_hi    <= 16'd0;
      dq_out      <= 16'd0;
      dq_oe       <= 1'b0;
      is_wr       <= 1'b0;
      dataMem_out <= 32'd0;
      SRAM_ADDR   <= 18'd0;
      SRAM_WE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            wa        <= ALU_result[18:2];
            wdata_hi  <= ST_value[31:16];
            is_wr     <= MEM_W_EN;
            cnt       <= 4'd0;
            state     <= LO;
            SRAM_ADDR <= {ALU_result[18:2], 1'b0};
            dq_out    <= ST_value[15:0];
            dq_oe     <= MEM_W_EN;
            SRAM_WE_N <= ~MEM_W_EN;
            SRAM_OE_N <= MEM_W_EN;
          end
        end
        LO: begin
          if (cnt == LAST) begin
            if (!is_wr) dataMem_out[15:0] <= SRAM_DQ;
            cnt       <= 4'd0;
            state     <= HI;
            SRAM_ADDR <= {wa, 1'b1};
            dq_out    <= wdata_hi;
            SRAM_WE_N <= ~is_wr;
          end else begin
            // WE_N rises for the final cycle of the phase so address and data outlast it.
            cnt       <= cnt_nxt;
            SRAM_WE_N <= ~(is_wr && (cnt_nxt < LAST));
          end
        end
        HI: begin
          if (cnt == LAST) begin
            if (!is_wr) dataMem_out[31:16] <= SRAM_DQ;
            cnt       <= 4'd0;
            state     <= DONE;
            dq_oe     <= 1'b0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
          end else begin
            cnt       <= cnt_nxt;
            SRAM_WE_N <= ~(is_wr && (cnt_nxt < LAST));
          end
        end
        // Always return to IDLE so a request still held high is not reissued.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: two instances (WAIT_CYCLES 1 and 3), each with a behavioural SRAM.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic probe;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // Instance A, WAIT_CYCLES = 1
  logic        a_r_en, a_w_en;
  logic [31:0] a_addr, a_st, a_dout;
  logic        a_ready, a_we_n, a_oe_n, a_ce_n, a_ub_n, a_lb_n;
  logic [17:0] a_sa;
  wire  [15:0] a_dq;
  logic [15:0] a_mem [0:1023];

  // Instance B, WAIT_CYCLES = 3
  logic        b_r_en, b_w_en;
  logic [31:0] b_addr, b_st, b_dout;
  logic        b_ready, b_we_n, b_oe_n, b_ce_n, b_ub_n, b_lb_n;
  logic [17:0] b_sa;
  wire  [15:0] b_dq;
  logic [15:0] b_mem [0:1023];

  sram_mem_ctrl #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .MEM_R_EN(a_r_en), .MEM_W_EN(a_w_en),
    .ALU_result(a_addr), .ST_value(a_st), .dataMem_out(a_dout), .ready(a_ready),
    .SRAM_ADDR(a_sa), .SRAM_DQ(a_dq), .SRAM_WE_N(a_we_n), .SRAM_OE_N(a_oe_n),
    .SRAM_CE_N(a_ce_n), .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .MEM_R_EN(b_r_en), .MEM_W_EN(b_w_en),
    .ALU_result(b_addr), .ST_value(b_st), .dataMem_out(b_dout), .ready(b_ready),
    .SRAM_ADDR(b_sa), .SRAM_DQ(b_dq), .SRAM_WE_N(b_we_n), .SRAM_OE_N(b_oe_n),
    .SRAM_CE_N(b_ce_n), .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n)
  );

  // SRAM models: read while OE low and WE high, write on WE rising edge.
  // probe drives 0 onto an idle bus so a controller that wrongly drives shows up.
  assign a_dq = (!a_oe_n && a_we_n) ? a_mem[a_sa[9:0]] : ((probe && a_oe_n) ? 16'h0000 : 16'hzzzz);
  assign b_dq = (!b_oe_n && b_we_n) ? b_mem[b_sa[9:0]] : ((probe && b_oe_n) ? 16'h0000 : 16'hzzzz);

  always @(posedge a_we_n) if (!rst) a_mem[a_sa[9:0]] <= a_dq;
  always @(posedge b_we_n) if (!rst) b_mem[b_sa[9:0]] <= b_dq;

  logic        m_ready, m_we_n, m_oe_n;
  logic [17:0] m_sa;
  logic [31:0] m_dout;
  logic        sel;

  always_comb begin
    m_ready = sel ? b_ready : a_ready;
    m_we_n  = sel ? b_we_n  : a_we_n;
    m_oe_n  = sel ? b_oe_n  : a_oe_n;
    m_sa    = sel ? b_sa    : a_sa;
    m_dout  = sel ? b_dout  : a_dout;
  end

  // Issue one request from posedge+1 and follow it until ready; returns at posedge+1 after DONE.
  task automatic access(input bit s, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, output int stall, output int we_lo,
                        output int we_hi, output logic [17:0] first_sa,
                        output logic [17:0] last_sa, output logic [31:0] dout_done);
    logic [17:0] lo_a;
    bit done;
    bit seen;
    lo_a = {addr[18:2], 1'b0};
    sel = s;
    if (s) begin b_r_en = rd; b_w_en = wr; b_addr = addr; b_st = data; end
    else   begin a_r_en = rd; a_w_en = wr; a_addr = addr; a_st = data; end
    stall = 0; we_lo = 0; we_hi = 0; first_sa = '0; last_sa = '0; dout_done = '0;
    done = 0; seen = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (m_ready) begin
        done = 1;
        dout_done = m_dout;
      end else begin
        stall++;
        if (!m_we_n && m_sa == lo_a) we_lo++;
        if (!m_we_n && m_sa == (lo_a | 18'd1)) we_hi++;
        if (!m_we_n || !m_oe_n) begin
          if (!seen) first_sa = m_sa;
          seen = 1;
          last_sa = m_sa;
        end
        // Scramble inputs mid-access; the latched address and data must be used.
        if (stall == 2) begin
          if (s) begin b_addr = ~addr; b_st = ~data; end
          else   begin a_addr = ~addr; a_st = ~data; end
        end
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL access_timeout: ready never rose for addr %h (stall %0d, required <= 40)", addr, stall);
    end
    @(posedge clk); #1;
    if (s) begin b_r_en = 0; b_w_en = 0; end
    else   begin a_r_en = 0; a_w_en = 0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    probe = 1'b1;
    a_r_en = 1'b1;
    #1;
    compared++;
    if (a_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready_req: got %b required 0", a_ready); end
    a_r_en = 1'b0;
    #1;
    compared++;
    if (a_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready_idle: got %b required 1", a_ready); end
    compared++;
    if (a_dout !== 32'd0) begin mismatched++; $display("FAIL reset_dout: got %h required 0", a_dout); end
    compared++;
    if (a_sa !== 18'd0) begin mismatched++; $display("FAIL reset_addr: got %h required 0", a_sa); end
    compared++;
    if ({a_we_n, a_oe_n} !== 2'b11) begin mismatched++; $display("FAIL reset_we_oe: got %b required 11", {a_we_n, a_oe_n}); end
    compared++;
    if (a_dq !== 16'h0000) begin mismatched++; $display("FAIL reset_bus_released: got %h required 0000", a_dq); end
    compared++;
    if ({a_ce_n, a_ub_n, a_lb_n} !== 3'b000) begin mismatched++; $display("FAIL tie_offs: got %b required 000", {a_ce_n, a_ub_n, a_lb_n}); end
    compared++;
    if ({b_ready, b_we_n, b_oe_n} !== 3'b111) begin mismatched++; $display("FAIL reset_b: got %b required 111", {b_ready, b_we_n, b_oe_n}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    probe = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ready !== 1'b1 || a_we_n !== 1'b1 || a_oe_n !== 1'b1 || a_dq !== 16'h0000) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL idle_quiet: got %0d bad cycles required 0", bad); end
    probe = 1'b0;
  endtask

  task automatic test_store_load();
    int st, wl, wh;
    logic [17:0] fs, ls;
    logic [31:0] d;
    @(posedge clk); #1;
    access(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, st, wl, wh, fs, ls, d);
    compared++;
    if (st != 5) begin mismatched++; $display("FAIL store_stall: got %0d required 5", st); end
    compared++;
    if (wl != 1 || wh != 1) begin mismatched++; $display("FAIL store_we_pulses: got lo %0d hi %0d required 1 1", wl, wh); end
    compared++;
    if (a_mem[8] !== 16'hBEEF) begin mismatched++; $display("FAIL store_lo_word: got %h required beef", a_mem[8]); end
    compared++;
    if (a_mem[9] !== 16'hDEAD) begin mismatched++; $display("FAIL store_hi_word: got %h required dead", a_mem[9]); end
    access(0, 1, 0, 32'h0000_0010, 32'h0, st, wl, wh, fs, ls, d);
    compared++;
    if (d !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL load_data: got %h required deadbeef", d); end
    compared++;
    if (st != 5) begin mismatched++; $display("FAIL load_stall: got %0d required 5", st); end
    compared++;
    if (fs !== 18'd8 || ls !== 18'd9) begin mismatched++; $display("FAIL load_addrs: got %h/%h required 8/9", fs, ls); end
  endtask

  task automatic test_back_to_back();
    int st1, st2, wl, wh;
    logic [17:0] fs1, ls1, fs2, ls2;
    logic [31:0] d1, d2;
    a_mem[2] = 16'h1111; a_mem[3] = 16'h2222; a_mem[4] = 16'h3333; a_mem[5] = 16'h4444;
    @(posedge clk); #1;
    access(0, 1, 0, 32'h0000_0004, 32'h0, st1, wl, wh, fs1, ls1, d1);
    access(0, 1, 0, 32'h0000_0008, 32'h0, st2, wl, wh, fs2, ls2, d2);
    compared++;
    if (d1 !== 32'h2222_1111) begin mismatched++; $display("FAIL b2b_data0: got %h required 22221111", d1); end
    compared++;
    if (d2 !== 32'h4444_3333) begin mismatched++; $display("FAIL b2b_data1: got %h required 44443333", d2); end
    compared++;
    if (st1 != 5 || st2 != 5) begin mismatched++; $display("FAIL b2b_stalls: got %0d/%0d required 5/5", st1, st2); end
    compared++;
    if (fs1 !== 18'd2 || ls1 !== 18'd3 || fs2 !== 18'd4 || ls2 !== 18'd5) begin
      mismatched++;
      $display("FAIL b2b_addrs: got %h/%h %h/%h required 2/3 4/5", fs1, ls1, fs2, ls2);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (a_dout !== 32'h4444_3333) begin mismatched++; $display("FAIL dout_hold: got %h required 44443333", a_dout); end
  endtask

  task automatic test_both_enables();
    int st, wl, wh;
    logic [17:0] fs, ls;
    logic [31:0] d;
    @(posedge clk); #1;
    access(0, 1, 1, 32'h0000_0020, 32'hCAFE_F00D, st, wl, wh, fs, ls, d);
    compared++;
    if (a_mem[16] !== 16'hF00D || a_mem[17] !== 16'hCAFE) begin
      mismatched++;
      $display("FAIL both_en_write: got %h%h required cafef00d", a_mem[17], a_mem[16]);
    end
    compared++;
    if (d !== 32'h4444_3333) begin mismatched++; $display("FAIL both_en_dout: got %h required 44443333", d); end
    compared++;
    if (wl != 1 || wh != 1 || st != 5) begin mismatched++; $display("FAIL both_en_timing: got wl %0d wh %0d stall %0d required 1 1 5", wl, wh, st); end
  endtask

  task automatic test_wait3();
    int st, wl, wh;
    logic [17:0] fs, ls;
    logic [31:0] d;
    @(posedge clk); #1;
    access(1, 0, 1, 32'h0000_0043, 32'h1234_5678, st, wl, wh, fs, ls, d);
    compared++;
    if (st != 9) begin mismatched++; $display("FAIL w3_store_stall: got %0d required 9", st); end
    compared++;
    if (wl != 3 || wh != 3) begin mismatched++; $display("FAIL w3_we_low: got lo %0d hi %0d required 3 3", wl, wh); end
    compared++;
    if (b_mem[32] !== 16'h5678 || b_mem[33] !== 16'h1234) begin
      mismatched++;
      $display("FAIL w3_mem: got %h%h required 12345678", b_mem[33], b_mem[32]);
    end
    access(1, 1, 0, 32'h0000_0040, 32'h0, st, wl, wh, fs, ls, d);
    compared++;
    if (d !== 32'h1234_5678 || st != 9) begin mismatched++; $display("FAIL w3_load: got %h stall %0d required 12345678 stall 9", d, st); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int st, wl, wh;
    logic [17:0] fs, ls;
    logic [31:0] d;
    @(posedge clk); #1;
    a_w_en = 1'b1; a_addr = 32'h0000_0030; a_st = 32'h55AA_55AA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    probe = 1'b1;
    #1;
    compared++;
    if (a_we_n !== 1'b1 || a_oe_n !== 1'b1) begin mismatched++; $display("FAIL midrst_we_oe: got %b%b required 11", a_we_n, a_oe_n); end
    compared++;
    if (a_dq !== 16'h0000) begin mismatched++; $display("FAIL midrst_bus: got %h required 0000", a_dq); end
    compared++;
    if (a_dout !== 32'd0) begin mismatched++; $display("FAIL midrst_dout: got %h required 0", a_dout); end
    a_w_en = 1'b0;
    #1;
    compared++;
    if (a_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_idle: got ready %b required 1", a_ready); end
    probe = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(0, 1, 0, 32'h0000_0010, 32'h0, st, wl, wh, fs, ls, d);
    compared++;
    if (d !== 32'hDEAD_BEEF || st != 5) begin mismatched++; $display("FAIL midrst_reload: got %h stall %0d required deadbeef stall 5", d, st); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    probe = 1'b0;
    sel = 1'b0;
    a_r_en = 0; a_w_en = 0; a_addr = 0; a_st = 0;
    b_r_en = 0; b_w_en = 0; b_addr = 0; b_st = 0;
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = 16'h0000;
      b_mem[i] = 16'h0000;
    end
    test_reset();
    test_idle();
    test_store_load();
    test_back_to_back();
    test_both_enables();
    test_wait3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Multi-cycle data-memory controller that replaces the single-cycle data array behind the MEM stage with the board's external 256K×16 asynchronous SRAM. It takes the MEM-stage request (MEM_R_EN, MEM_W_EN, ALU_result, ST_value) from the EXE2MEM register and splits each 32-bit access into two 16-bit SRAM accesses. It returns read data to MEM2WB and drives `ready` low to freeze every pipeline register and the PC until the access completes.

## Interface
- WAIT_CYCLES, 1: cycles WE_N is held low per half-word write; each half-word phase lasts WAIT_CYCLES+1 cycles. Legal range 1–15.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- MEM_R_EN  in  1  load request from EXE2MEM
- MEM_W_EN  in  1  store request from EXE2MEM
- ALU_result  in  32  byte address
- ST_value  in  32  store data
- dataMem_out  out  32  load data, registered, to MEM2WB
- ready  out  1  1 = pipeline may advance. 0 = freeze all pipeline registers and the PC.
- SRAM_ADDR  out  18  half-word address
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_WE_N  out  1  write enable, active low
- SRAM_OE_N  out  1  output enable, active low
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0

## Operation
- The controller has four states: IDLE, LO, HI and DONE. It contains a phase counter `cnt` that is 4 bits wide.
- Request: `req = MEM_R_EN | MEM_W_EN`. A write takes priority when both enables are high; `dataMem_out` is then unchanged.
- ready is combinational:
  - `ready = (state==DONE) | (state==IDLE & ~req)`.
  - This means a request pulls `ready` low in the same cycle it appears in IDLE.
- IDLE with req:
  - Latch word address `wa = ALU_result[18:2]`.
  - Latch write data and the op type (write wins).
  - Clear `cnt` and go to LO.
  - `ALU_result[1:0]` is ignored.
- LO: `SRAM_ADDR = {wa,1'b0}`. HI: `SRAM_ADDR = {wa,1'b1}`.
- Each of LO and HI lasts WAIT_CYCLES+1 cycles, counted by `cnt`. LO advances to HI; HI advances to DONE.
- Write phase:
  - SRAM_DQ is driven with the low half in LO and the high half in HI.
  - SRAM_WE_N is 0 for the first WAIT_CYCLES cycles and 1 in the last cycle, so the address is stable around the WE rising edge.
  - SRAM_OE_N is 1 throughout.
- Read phase:
  - SRAM_DQ is Z, SRAM_OE_N = 0 and SRAM_WE_N = 1.
  - On the last cycle of LO, capture SRAM_DQ into `dataMem_out[15:0]`; on the last cycle of HI, capture it into `dataMem_out[31:16]`.
- DONE: `ready = 1` for exactly one cycle, and the pipeline advances at this edge. The next state is always IDLE, even if req is still high, so the same request is never reissued.
- Back-to-back memory instructions: the next request is seen in IDLE on the cycle after DONE.
- Outside LO and HI: SRAM_DQ = Z, SRAM_WE_N = 1, SRAM_OE_N = 1, and SRAM_ADDR holds its last value.

## Timing
- Reset values:
  - State: IDLE. `cnt = 0`.
  - Outputs: dataMem_out = 0, SRAM_ADDR = 0, SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ = Z.
  - `ready = ~req`.
- A request first seen in IDLE at cycle 0:
  - LO occupies cycles 1..W+1, HI occupies W+2..2W+2, and DONE is cycle 2W+3.
  - ready is low in cycles 0..2W+2 and high in cycle 2W+3. With the default W = 1, ready is low for cycles 0–4 and high in cycle 5.
- `dataMem_out` is valid from the start of DONE. It holds until the next read completes and is not cleared between accesses.
- With no memory instruction, ready stays 1 and there is zero added latency.
- Reset mid-access:
  - The controller returns immediately to IDLE, WE_N = 1 and DQ = Z, with no partial write completion.
  - A half-written word is acceptable.
- `wa` and the write data are latched, so input changes during LO, HI or DONE have no effect.

## Test plan
- Store then load: store ST_value = 0xDEADBEEF to address 0x0000_0010. Required:
  - SRAM_ADDR 8 receives 0xBEEF with one WE_N low pulse.
  - SRAM_ADDR 9 receives 0xDEAD.
  - ready is low for 5 cycles.
  - A load from 0x10 then returns 0xDEADBEEF in DONE.
- Idle pipeline (no R/W enables for 20 cycles): ready stays 1, WE_N = 1, OE_N = 1, DQ = Z throughout.
- Back-to-back loads from addresses 0x4 and 0x8: each gets its own 6-cycle window, with SRAM_ADDR 2/3 then 4/5. A single cycle of ready=1 separates the two stalls.
- MEM_R_EN and MEM_W_EN both high: a write occurs and dataMem_out keeps its previous value.
- WAIT_CYCLES = 3 with a store:
  - WE_N is low for 3 cycles in each phase.
  - ready is low for cycles 0–8 and high in cycle 9.
- Reset asserted in cycle 2 of a store: state goes to IDLE immediately, WE_N = 1, DQ = Z, dataMem_out = 0; a subsequent load then completes normally.
